// File: rtl/keypad_scanner.sv
// 4x4 keypad scan controller: one-hot row drive, synchronised column sampling,
// press/release debounce and registered key events. Define AUTOREPEAT_EN for held-key repeat.
module keypad_scanner #(
  parameter int SCAN_DIV      = 1000,
  parameter int DEBOUNCE_CNT  = 8,
  parameter int REPEAT_DELAY  = 64,
  parameter int REPEAT_PERIOD = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] col_in,
  output logic [3:0] row_out,
  output logic [3:0] dec_row,
  output logic [3:0] dec_col,
  input  logic [3:0] dec_value,
  input  logic       dec_valid_in,
  input  logic       dec_valid_dig,
  input  logic       dec_valid_lr,
  output logic       key_strobe,
  output logic [3:0] key_value,
  output logic       key_in,
  output logic       key_dig,
  output logic       key_lr,
  output logic       key_held
);
  localparam int DW = $clog2(SCAN_DIV + 1);
  localparam int BW = $clog2(DEBOUNCE_CNT + 1);

  if (SCAN_DIV < 2 || DEBOUNCE_CNT < 2 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_param_check
    $error("keypad_scanner: parameter out of range");
  end

  typedef enum logic [1:0] {SCAN = 2'd0, DEBOUNCE = 2'd1, PRESSED = 2'd2, RELEASE = 2'd3} state_t;

  state_t      r_state, w_state_nxt;
  logic [3:0]  r_sync1, r_sync2;
  logic [DW-1:0] r_dwell;
  logic [BW-1:0] r_cnt, w_cnt_nxt, w_cnt_inc;
  logic [3:0]  r_row, w_row_nxt, w_row_rot;
  logic [3:0]  r_col, w_col_nxt;
  logic        r_strobe, w_strobe_nxt;
  logic        r_held, w_held_nxt;
  logic        w_load, w_sample, w_onehot;
  logic [3:0]  r_key_value;
  logic        r_key_in, r_key_dig, r_key_lr;

`ifdef AUTOREPEAT_EN
  localparam int RW = $clog2(((REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD) + 1);
  logic [RW-1:0] r_rep, w_rep_nxt, w_rep_inc;
  logic          r_armed, w_armed_nxt;
`endif

  assign w_sample  = (r_dwell == DW'(SCAN_DIV - 1));
  assign w_onehot  = (r_sync2 != 4'b0000) && ((r_sync2 & (r_sync2 - 4'd1)) == 4'b0000);
  assign w_cnt_inc = r_cnt + BW'(1);
  assign w_row_rot = {r_row[2:0], r_row[3]};

  // Column synchroniser and row dwell timer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= 4'b0000;
      r_sync2 <= 4'b0000;
      r_dwell <= '0;
    end else begin
      r_sync1 <= col_in;
      r_sync2 <= r_sync1;
      r_dwell <= w_sample ? '0 : r_dwell + DW'(1);
    end
  end

  // Scan FSM state and registered key outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= SCAN;
      r_cnt       <= '0;
      r_row       <= 4'b0001;
      r_col       <= 4'b0000;
      r_strobe    <= 1'b0;
      r_held      <= 1'b0;
      r_key_value <= 4'd0;
      r_key_in    <= 1'b0;
      r_key_dig   <= 1'b0;
      r_key_lr    <= 1'b0;
`ifdef AUTOREPEAT_EN
      r_rep       <= '0;
      r_armed     <= 1'b0;
`endif
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_row    <= w_row_nxt;
      r_col    <= w_col_nxt;
      r_strobe <= w_strobe_nxt;
      r_held   <= w_held_nxt;
      if (w_load) begin
        r_key_value <= dec_value;
        r_key_in    <= dec_valid_in;
        r_key_dig   <= dec_valid_dig;
        r_key_lr    <= dec_valid_lr;
      end
`ifdef AUTOREPEAT_EN
      r_rep   <= w_rep_nxt;
      r_armed <= w_armed_nxt;
`endif
    end
  end

  // Next-state and next-output decode; everything advances only on a sample cycle
  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_row_nxt    = r_row;
    w_col_nxt    = r_col;
    w_strobe_nxt = 1'b0;
    w_held_nxt   = r_held;
    w_load       = 1'b0;
`ifdef AUTOREPEAT_EN
    w_rep_nxt    = r_rep;
    w_armed_nxt  = r_armed;
    w_rep_inc    = r_rep + RW'(1);
`endif
    if (w_sample) begin
      case (r_state)
        SCAN: begin
          if (w_onehot) begin
            w_col_nxt   = r_sync2;
            w_cnt_nxt   = BW'(1);
            w_state_nxt = DEBOUNCE;
          end else begin
            w_row_nxt   = w_row_rot;
          end
        end
        DEBOUNCE: begin
          if (r_sync2 != r_col) begin
            w_col_nxt   = 4'b0000;
            w_row_nxt   = w_row_rot;
            w_cnt_nxt   = '0;
            w_state_nxt = SCAN;
          end else if (w_cnt_inc == BW'(DEBOUNCE_CNT)) begin
            w_cnt_nxt    = '0;
            w_state_nxt  = PRESSED;
            w_load       = 1'b1;
            w_strobe_nxt = 1'b1;
            w_held_nxt   = 1'b1;
          end else begin
            w_cnt_nxt    = w_cnt_inc;
          end
        end
        PRESSED: begin
          if (r_sync2 == 4'b0000) begin
            w_cnt_nxt   = BW'(1);
            w_state_nxt = RELEASE;
`ifdef AUTOREPEAT_EN
            w_rep_nxt   = '0;
            w_armed_nxt = 1'b0;
`endif
          end else begin
`ifdef AUTOREPEAT_EN
            // Repeat timer counts held samples only; non-input keys (L/R) restart it silently
            if ((!r_armed && w_rep_inc == RW'(REPEAT_DELAY)) ||
                (r_armed && w_rep_inc == RW'(REPEAT_PERIOD))) begin
              w_rep_nxt    = '0;
              w_armed_nxt  = 1'b1;
              w_load       = dec_valid_in;
              w_strobe_nxt = dec_valid_in;
            end else begin
              w_rep_nxt    = w_rep_inc;
            end
`else
            w_state_nxt = PRESSED;
`endif
          end
        end
        RELEASE: begin
          if (r_sync2 != 4'b0000) begin
            w_cnt_nxt   = '0;
            w_state_nxt = PRESSED;
          end else if (w_cnt_inc == BW'(DEBOUNCE_CNT)) begin
            w_cnt_nxt   = '0;
            w_held_nxt  = 1'b0;
            w_col_nxt   = 4'b0000;
            w_row_nxt   = w_row_rot;
            w_state_nxt = SCAN;
          end else begin
            w_cnt_nxt   = w_cnt_inc;
          end
        end
        default: begin
          w_state_nxt = SCAN;
          w_cnt_nxt   = '0;
          w_col_nxt   = 4'b0000;
          w_row_nxt   = 4'b0001;
          w_held_nxt  = 1'b0;
        end
      endcase
    end else begin
      w_state_nxt = r_state;
    end
  end

  assign row_out    = r_row;
  assign dec_row    = r_row;
  assign dec_col    = r_col;
  assign key_strobe = r_strobe;
  assign key_value  = r_key_value;
  assign key_in     = r_key_in;
  assign key_dig    = r_key_dig;
  assign key_lr     = r_key_lr;
  assign key_held   = r_held;
endmodule
